// File: rtl/dht_sched_pkg.sv
// Shared state encoding and default timing for the DHT11 read scheduler.
package dht_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_EVAL      = 3'd4
  } sched_state_e;

  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_PERIOD_MS    = 2000;
  localparam int DEF_MIN_GAP_MS   = 1000;
  localparam int DEF_RETRY_GAP_MS = 1100;
  localparam int DEF_TIMEOUT_MS   = 30;
  localparam int DEF_MAX_RETRY    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dht11_scheduler_tick_gen.sv
// Free-running 1 ms tick: a down-counter that reloads at terminal count.
module tick_gen_1m #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == '0) begin
      cnt_q <= CNT_W'(DIV - 1);
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 periodic read scheduler: spacing, timeout recovery, retries, last-good data hold.
// States: IDLE=off | GAP=spacing wait | START=pulse | WAIT_DONE=await done/timeout | EVAL=judge. DHT_SCHED_STATS_EN adds counters.
module dht11_scheduler
  import dht_sched_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int PERIOD_MS    = DEF_PERIOD_MS,
  parameter int MIN_GAP_MS   = DEF_MIN_GAP_MS,
  parameter int RETRY_GAP_MS = DEF_RETRY_GAP_MS,
  parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        trig_i,
  output logic        dht_start_o,
  output logic        dht_rst_o,
  input  logic        dht_done_i,
  input  logic        dht_valid_i,
  input  logic [15:0] dht_humidity_i,
  input  logic [15:0] dht_temperature_i,
  output logic [15:0] humidity_o,
  output logic [15:0] temperature_o,
  output logic        data_valid_o,
  output logic        update_o,
  output logic        fail_o,
  output logic        busy_o,
  output logic [2:0]  state_dbg_o
`ifdef DHT_SCHED_STATS_EN
  ,
  output logic [15:0] ok_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] timeout_cnt_o
`endif
);

  localparam int MS_W = $clog2(max_int(PERIOD_MS, RETRY_GAP_MS) + 1);
  localparam int RC_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [MS_W-1:0] PERIOD_C    = MS_W'(PERIOD_MS);
  localparam logic [MS_W-1:0] MIN_GAP_C   = MS_W'(MIN_GAP_MS);
  localparam logic [MS_W-1:0] RETRY_GAP_C = MS_W'(RETRY_GAP_MS);
  localparam logic [MS_W-1:0] TIMEOUT_C   = MS_W'(TIMEOUT_MS);
  localparam logic [RC_W-1:0] RETRY_LAST_C = RC_W'(MAX_RETRY - 1);

  sched_state_e    state_q;
  logic            tick_1ms;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d, gap_target_q;
  logic [RC_W-1:0] retry_cnt_q;
  logic            pending_q, done_q, timeout_q;
  logic            dht_start_q, dht_rst_q, update_q, fail_q, busy_q, data_valid_q;
  logic [15:0]     humidity_q, temperature_q;

  tick_gen_1m #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick_1ms)
  );

  assign ms_cnt_d = (ms_cnt_q == '1) ? ms_cnt_q : ms_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      ms_cnt_q      <= '0;
      gap_target_q  <= '0;
      retry_cnt_q   <= '0;
      pending_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      dht_start_q   <= 1'b0;
      dht_rst_q     <= 1'b0;
      update_q      <= 1'b0;
      fail_q        <= 1'b0;
      busy_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      humidity_q    <= '0;
      temperature_q <= '0;
    end else begin
      done_q      <= dht_done_i;
      dht_start_q <= 1'b0;
      dht_rst_q   <= 1'b0;
      update_q    <= 1'b0;
      fail_q      <= 1'b0;
      if (tick_1ms) ms_cnt_q <= ms_cnt_d;

      unique case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_q      <= ST_GAP;
            gap_target_q <= MIN_GAP_C;
            ms_cnt_q     <= '0;
          end
        end
        ST_GAP: begin
          if (!enable_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
          end else if ((ms_cnt_q >= gap_target_q) ||
                       ((pending_q || trig_i) && (ms_cnt_q >= MIN_GAP_C))) begin
            state_q     <= ST_START;
            pending_q   <= 1'b0;
            ms_cnt_q    <= '0;
            dht_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (trig_i) begin
            pending_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q   <= ST_WAIT_DONE;
          timeout_q <= 1'b0;
          if (trig_i) pending_q <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (trig_i) pending_q <= 1'b1;
          // Only the falling edge matters: data registers settle while done is high.
          if (done_q && !dht_done_i) begin
            state_q <= ST_EVAL;
          end else if (ms_cnt_q == TIMEOUT_C) begin
            state_q   <= ST_EVAL;
            timeout_q <= 1'b1;
            dht_rst_q <= 1'b1;
          end
        end
        ST_EVAL: begin
          ms_cnt_q <= '0;
          busy_q   <= 1'b0;
          if (enable_i) begin
            state_q <= ST_GAP;
            if (trig_i) pending_q <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
          end
          if (!timeout_q && dht_valid_i) begin
            humidity_q    <= dht_humidity_i;
            temperature_q <= dht_temperature_i;
            update_q      <= 1'b1;
            data_valid_q  <= 1'b1;
            retry_cnt_q   <= '0;
            gap_target_q  <= PERIOD_C;
          end else if (retry_cnt_q == RETRY_LAST_C) begin
            fail_q       <= 1'b1;
            retry_cnt_q  <= '0;
            gap_target_q <= PERIOD_C;
          end else begin
            retry_cnt_q  <= retry_cnt_q + 1'b1;
            gap_target_q <= RETRY_GAP_C;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dht_start_o   = dht_start_q;
  assign dht_rst_o     = dht_rst_q;
  assign humidity_o    = humidity_q;
  assign temperature_o = temperature_q;
  assign data_valid_o  = data_valid_q;
  assign update_o      = update_q;
  assign fail_o        = fail_q;
  assign busy_o        = busy_q;
  assign state_dbg_o   = state_q;

`ifdef DHT_SCHED_STATS_EN
  logic [15:0] ok_cnt_q, err_cnt_q, timeout_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ok_cnt_q      <= '0;
      err_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else if (state_q == ST_EVAL) begin
      if (timeout_q) begin
        if (timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end else if (dht_valid_i) begin
        if (ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + 1'b1;
      end else begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign ok_cnt_o      = ok_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign timeout_cnt_o = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_dht11_scheduler.sv
// Directed bench for dht11_scheduler with a behavioural DHT11 controller and a data scoreboard.
module tb_dht11_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, trig;
  logic        dht_done, dht_valid;
  logic [15:0] dht_hum, dht_temp;
  logic        dht_start_o, dht_rst_o, data_valid_o, update_o, fail_o, busy_o;
  logic [15:0] humidity_o, temperature_o;
  logic [2:0]  state_dbg_o;
`ifdef DHT_SCHED_STATS_EN
  logic [15:0] ok_cnt_o, err_cnt_o, timeout_cnt_o;
`endif

  typedef struct {
    logic [15:0] hum;
    logic [15:0] temp;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0, upd_cnt = 0, fail_cnt = 0;

  int          m_cnt, m_delay;
  logic        m_hang, m_valid;
  logic [15:0] m_hum, m_temp;

  dht11_scheduler #(
    .CLK_HZ(100_000), .PERIOD_MS(20), .MIN_GAP_MS(10),
    .RETRY_GAP_MS(11), .TIMEOUT_MS(5), .MAX_RETRY(2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .enable_i          (enable),
    .trig_i            (trig),
    .dht_start_o       (dht_start_o),
    .dht_rst_o         (dht_rst_o),
    .dht_done_i        (dht_done),
    .dht_valid_i       (dht_valid),
    .dht_humidity_i    (dht_hum),
    .dht_temperature_i (dht_temp),
    .humidity_o        (humidity_o),
    .temperature_o     (temperature_o),
    .data_valid_o      (data_valid_o),
    .update_o          (update_o),
    .fail_o            (fail_o),
    .busy_o            (busy_o),
    .state_dbg_o       (state_dbg_o)
`ifdef DHT_SCHED_STATS_EN
    ,
    .ok_cnt_o          (ok_cnt_o),
    .err_cnt_o         (err_cnt_o),
    .timeout_cnt_o     (timeout_cnt_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d cycles expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // kind: 0 dht_start, 1 update, 2 dht_rst
  task automatic wait_pulse(input int kind, input int bound, input string tag, output int at);
    logic seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      case (kind)
        0:       seen = dht_start_o;
        1:       seen = update_o;
        default: seen = dht_rst_o;
      endcase
      if (seen) at = cyc;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  // Pulse monitor and data scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (dht_start_o) start_cnt++;
      if (fail_o) fail_cnt++;
      if (update_o) begin
        upd_cnt++;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check("sb_humidity", 32'(humidity_o), 32'(sb_e.hum));
          check("sb_temperature", 32'(temperature_o), 32'(sb_e.temp));
        end
      end
    end
  end

  // Behavioural DHT11 controller: done pulse of 5 cycles, m_delay cycles after start
  initial begin
    dht_done = 1'b0; dht_valid = 1'b0; dht_hum = '0; dht_temp = '0;
    m_cnt = -1;
    forever begin
      @(negedge clk);
      if (rst || dht_rst_o) begin
        m_cnt = -1;
        dht_done = 1'b0;
      end else if (dht_start_o) begin
        m_cnt = 0;
      end else if (m_cnt >= 0) begin
        m_cnt++;
        if (!m_hang) begin
          if (m_cnt == m_delay) begin
            dht_done = 1'b1; dht_valid = m_valid; dht_hum = m_hum; dht_temp = m_temp;
          end else if (m_cnt == m_delay + 5) begin
            dht_done = 1'b0;
            m_cnt = -1;
          end
        end
      end
    end
  end

  initial begin
    int e, s1, u1, s2, s3, s4, r4, s5, u5, s6, u6, s7, st;
    rst = 1'b1; enable = 1'b0; trig = 1'b0;
    m_delay = 200; m_hang = 1'b0; m_valid = 1'b1; m_hum = 16'h3700; m_temp = 16'h1A00;
    repeat (5) @(negedge clk);
    check("rst_state", 32'(state_dbg_o), 32'd0);
    check("rst_outs", {25'd0, dht_start_o, dht_rst_o, data_valid_o, update_o, fail_o, busy_o, 1'b0}, 32'd0);
    check("rst_data", {humidity_o, temperature_o}, 32'd0);
    rst = 1'b0;

    // trig ignored while disabled
    repeat (100) @(negedge clk);
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    repeat (1500) @(negedge clk);
    check("disabled_state", 32'(state_dbg_o), 32'd0);
    check("disabled_starts", 32'(start_cnt), 32'd0);

    // nominal read
    exp_q.push_back('{hum: 16'h3700, temp: 16'h1A00});
    enable = 1'b1; e = cyc;
    wait_pulse(0, 1500, "first_start", s1);
    check_range("first_start_time", s1 - e, 895, 1010);
    @(negedge clk);
    check("wait_state", 32'(state_dbg_o), 32'd3);
    check("busy_in_wait", 32'(busy_o), 32'd1);
    wait_pulse(1, 400, "update1", u1);
    check_range("done_to_update", u1 - s1, 205, 210);
    check("data_valid_set", 32'(data_valid_o), 32'd1);

    // checksum failures
    m_valid = 1'b0; m_hum = 16'hDEAD; m_temp = 16'hBEEF;
    wait_pulse(0, 2500, "periodic_start", s2);
    check_range("period_gap", s2 - u1, 1895, 2010);
    wait_pulse(0, 1500, "retry_start", s3);
    check_range("retry_gap", s3 - s2, 1195, 1320);
    check("fail_after_one", 32'(fail_cnt), 32'd0);
    check("no_update_bad", 32'(upd_cnt), 32'd1);
    wait_pulse(0, 2500, "after_fail_start", s4);
    check_range("fail_period_gap", s4 - s3, 2095, 2220);
    check("fail_once", 32'(fail_cnt), 32'd1);
    check("hold_data_bad", {humidity_o, temperature_o}, 32'h3700_1A00);

    // timeout
    m_hang = 1'b1;
    wait_pulse(2, 700, "timeout_rst", r4);
    check_range("timeout_time", r4 - s4, 395, 510);
    m_hang = 1'b0; m_valid = 1'b1; m_hum = 16'h4100; m_temp = 16'h1B00;
    exp_q.push_back('{hum: 16'h4100, temp: 16'h1B00});
    wait_pulse(0, 1300, "timeout_retry", s5);
    check_range("timeout_retry_gap", s5 - r4, 995, 1110);
    check("no_update_timeout", 32'(upd_cnt), 32'd1);
    check("hold_data_timeout", {humidity_o, temperature_o}, 32'h3700_1A00);
    check("fail_not_on_timeout", 32'(fail_cnt), 32'd1);
    wait_pulse(1, 400, "update5", u5);
    check_range("update5_latency", u5 - s5, 205, 210);

    // manual trigger 3 ms after a read
    repeat (300) @(negedge clk);
    m_hum = 16'h2A00; m_temp = 16'h1500;
    exp_q.push_back('{hum: 16'h2A00, temp: 16'h1500});
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    wait_pulse(0, 2500, "manual_start", s6);
    check_range("manual_start_time", s6 - u5, 895, 1010);

    // enable drop during WAIT_DONE
    repeat (50) @(negedge clk);
    check("drop_in_wait", 32'(state_dbg_o), 32'd3);
    enable = 1'b0;
    wait_pulse(1, 400, "drop_update", u6);
    repeat (3) @(negedge clk);
    check("drop_idle", 32'(state_dbg_o), 32'd0);
    check("drop_not_busy", 32'(busy_o), 32'd0);
    st = start_cnt;
    repeat (5000) @(negedge clk);
    check("drop_no_start", 32'(start_cnt), 32'(st));
    check("drop_data", {humidity_o, temperature_o}, 32'h2A00_1500);

    // reset mid-transaction
    enable = 1'b1;
    wait_pulse(0, 1500, "pre_reset_start", s7);
    repeat (50) @(negedge clk);
    check("reset_in_wait", 32'(state_dbg_o), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(state_dbg_o), 32'd0);
    check("midrst_outs", {25'd0, dht_start_o, dht_rst_o, data_valid_o, update_o, fail_o, busy_o, 1'b0}, 32'd0);
    check("midrst_data", {humidity_o, temperature_o}, 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
